irq_enc32: RTL and testbench

//  - Inverse of the team's 5-to-32 enable decoder: collects 32 request lines and encodes one pending request into a 5-bit index.
//  - Sticky pending register, per-line mask, master enable, valid/ack handshake toward the CPU interrupt/exception logic.
//  - One grant offered at a time; the granted pending bit is cleared when the grant is acknowledged.

---
 rtl/irq_enc_pkg.sv | 10 +
 rtl/pri_enc32.sv | 30 +++
 rtl/irq_enc32.sv | 81 ++++++++
 tb/tb_irq_enc32.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/irq_enc_pkg.sv
// Shared sizes and FSM encoding for the 32-line interrupt encoder.
package irq_enc_pkg;
    localparam int IRQ_N = 32;
    localparam int IRQ_W = 5;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_OFFER = 1'b1
    } irq_state_t;
endpackage

// File: rtl/pri_enc32.sv
// Combinational wrapping priority encoder: first set bit of r at or after start.
module pri_enc32
    import irq_enc_pkg::*;
(
    input  logic [IRQ_N-1:0] r,
    input  logic [IRQ_W-1:0] start,
    output logic [IRQ_W-1:0] idx,
    output logic             any
);
    logic [IRQ_N-1:0] rot;
    logic [IRQ_W-1:0] off;

    // Rotate so that bit 0 of rot is r[start]; the 5-bit index add wraps 31->0.
    genvar gi;
    generate
        for (gi = 0; gi < IRQ_N; gi++) begin : g_rot
            assign rot[gi] = r[start + IRQ_W'(gi)];
        end
    endgenerate

    always_comb begin
        off = '0;
        for (int i = IRQ_N - 1; i >= 0; i--) begin
            if (rot[i]) off = IRQ_W'(i);
        end
    end

    assign idx = start + off;
    assign any = |r;
endmodule

// File: rtl/irq_enc32.sv
// Sticky 32-line interrupt collector offering one index at a time over valid/ack.
// Define IRQ_ENC32_RR_EN for round-robin arbitration; default is lowest-index-first.
module irq_enc32
    import irq_enc_pkg::*;
(
    input  logic             clk,
    input  logic             clrn,
    input  logic [IRQ_N-1:0] req,
    input  logic [IRQ_N-1:0] mask,
    input  logic             ena,
    input  logic             ack,
    output logic             valid,
    output logic [IRQ_W-1:0] n,
    output logic [IRQ_N-1:0] pend
);
    irq_state_t       state_reg;
    logic [IRQ_N-1:0] pend_next;
    logic [IRQ_W-1:0] enc_idx;
    logic             enc_any;
    logic [IRQ_W-1:0] search_start;

    // A new request on the same edge as its acknowledge keeps the bit pending.
    genvar gi;
    generate
        for (gi = 0; gi < IRQ_N; gi++) begin : g_pend
            assign pend_next[gi] = req[gi] |
                                   (pend[gi] & ~(valid & ack & (n == IRQ_W'(gi))));
        end
    endgenerate

`ifdef IRQ_ENC32_RR_EN
    logic [IRQ_W-1:0] rr_ptr_reg;
    assign search_start = rr_ptr_reg + 1'b1;
`else
    assign search_start = '0;
`endif

    pri_enc32 u_pri_enc (
        .r     (pend & mask),
        .start (search_start),
        .idx   (enc_idx),
        .any   (enc_any)
    );

    always_ff @(posedge clk) begin
        if (!clrn) begin
            pend      <= '0;
            valid     <= 1'b0;
            n         <= '0;
            state_reg <= S_IDLE;
`ifdef IRQ_ENC32_RR_EN
            rr_ptr_reg <= IRQ_W'(IRQ_N - 1);
`endif
        end else begin
            pend <= pend_next;
            case (state_reg)
                S_IDLE: begin
                    if (ena && enc_any) begin
                        n         <= enc_idx;
                        valid     <= 1'b1;
                        state_reg <= S_OFFER;
                    end
                end
                S_OFFER: begin
                    // n stays frozen until the consumer takes it.
                    if (ack) begin
                        valid     <= 1'b0;
                        state_reg <= S_IDLE;
`ifdef IRQ_ENC32_RR_EN
                        rr_ptr_reg <= n;
`endif
                    end
                end
                default: begin
                    valid     <= 1'b0;
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_irq_enc32.sv
// Scoreboard bench for irq_enc32: expected indices queued at stimulus, popped per offer.
module tb_irq_enc32;
    logic        clk = 1'b0;
    logic        clrn;
    logic [31:0] req;
    logic [31:0] mask;
    logic        ena;
    logic        ack;
    logic        valid;
    logic [4:0]  n;
    logic [31:0] pend;

    int errors = 0;
    int checks = 0;
    logic [4:0] exp_q[$];

    irq_enc32 dut (
        .clk   (clk),
        .clrn  (clrn),
        .req   (req),
        .mask  (mask),
        .ena   (ena),
        .ack   (ack),
        .valid (valid),
        .n     (n),
        .pend  (pend)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    // Pop one expected index per offer, compare, acknowledge, check the bubble.
    task automatic drain(input string tag, input int cnt);
        bit ok;
        logic [4:0] exp;
        for (int k = 0; k < cnt; k++) begin
            wait_valid(ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL %s timeout waiting for offer %0d (valid=%b)", tag, k, valid);
                return;
            end
            exp = exp_q.pop_front();
            checks++;
            if (n !== exp) begin
                errors++;
                $display("FAIL %s offer %0d: n=%0d expected %0d", tag, k, n, exp);
            end else
                $display("%s offer %0d: n=%0d ok", tag, k, n);
            ack = 1'b1;
            step();
            ack = 1'b0;
            checks++;
            if (valid !== 1'b0) begin
                errors++;
                $display("FAIL %s bubble after ack %0d: valid=%b expected 0", tag, k, valid);
            end
        end
    endtask

    task automatic test_reset();
        clrn = 1'b0; req = '1; mask = '1; ena = 1'b1; ack = 1'b0;
        step();
        step();
        clrn = 1'b1; req = '0;
        checks++;
        if (valid !== 1'b0) begin errors++; $display("FAIL reset valid=%b expected 0", valid); end
        checks++;
        if (n !== 5'd0) begin errors++; $display("FAIL reset n=%0d expected 0", n); end
        checks++;
        if (pend !== 32'h0) begin errors++; $display("FAIL reset pend=%h expected 00000000", pend); end
        $display("reset: valid=%b n=%0d pend=%h", valid, n, pend);
    endtask

    task automatic test_basic();
        mask = '1; ena = 1'b1;
        req = 32'h0000_0028;
        exp_q.push_back(5'd3);
        exp_q.push_back(5'd5);
        step();
        req = '0;
        checks++;
        if (valid !== 1'b0) begin errors++; $display("FAIL basic latency: valid=%b one edge after req, expected 0", valid); end
        drain("basic", 2);
        step();
        checks++;
        if (valid !== 1'b0) begin errors++; $display("FAIL basic final valid=%b expected 0", valid); end
        checks++;
        if (pend !== 32'h0) begin errors++; $display("FAIL basic final pend=%h expected 00000000", pend); end
    endtask

    task automatic test_mask();
        mask = 32'h8000_0000;
        req = 32'h8000_0001;
        exp_q.push_back(5'd31);
        step();
        req = '0;
        drain("mask", 1);
        step();
        step();
        checks++;
        if (pend !== 32'h0000_0001) begin errors++; $display("FAIL mask retained pend=%h expected 00000001", pend); end
        checks++;
        if (valid !== 1'b0) begin errors++; $display("FAIL mask masked valid=%b expected 0", valid); end
        mask = '1;
        exp_q.push_back(5'd0);
        drain("mask", 1);
        checks++;
        if (pend !== 32'h0) begin errors++; $display("FAIL mask final pend=%h expected 00000000", pend); end
    endtask

    task automatic test_set_clear();
        bit ok;
        logic [4:0] exp;
        req = 32'h0000_0008;
        exp_q.push_back(5'd3);
        step();
        req = '0;
        wait_valid(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL setclr timeout valid=%b", valid); return; end
        exp = exp_q.pop_front();
        checks++;
        if (n !== exp) begin errors++; $display("FAIL setclr first n=%0d expected %0d", n, exp); end
        ack = 1'b1; req = 32'h0000_0008;
        exp_q.push_back(5'd3);
        step();
        ack = 1'b0; req = '0;
        checks++;
        if (pend !== 32'h0000_0008) begin errors++; $display("FAIL setclr pend=%h expected 00000008", pend); end
        drain("setclr", 1);
    endtask

    task automatic test_hold_reset();
        bit ok;
        logic [4:0] exp;
        req = 32'h0000_0010;
        exp_q.push_back(5'd4);
        step();
        req = '0;
        wait_valid(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL hold timeout valid=%b", valid); return; end
        exp = exp_q.pop_front();
        ena = 1'b0; mask = '0; req = 32'h0000_0001;
        for (int k = 0; k < 3; k++) begin
            step();
            req = '0;
            checks++;
            if (valid !== 1'b1 || n !== exp) begin
                errors++;
                $display("FAIL hold cycle %0d: valid=%b n=%0d expected 1/%0d", k, valid, n, exp);
            end
        end
        clrn = 1'b0; ack = 1'b1;
        step();
        clrn = 1'b1; ack = 1'b0; ena = 1'b1; mask = '1;
        checks++;
        if (valid !== 1'b0) begin errors++; $display("FAIL hold reset valid=%b expected 0", valid); end
        checks++;
        if (pend !== 32'h0) begin errors++; $display("FAIL hold reset pend=%h expected 00000000", pend); end
        checks++;
        if (n !== 5'd0) begin errors++; $display("FAIL hold reset n=%0d expected 0", n); end
    endtask

    task automatic test_arbitration();
`ifdef IRQ_ENC32_RR_EN
        logic [4:0] seq [6] = '{5'd0, 5'd1, 5'd31, 5'd0, 5'd1, 5'd31};
`else
        logic [4:0] seq [6] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
`endif
        req = 32'h8000_0003;
        foreach (seq[i]) exp_q.push_back(seq[i]);
        drain("arb", 6);
        req = '0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mask();
        test_set_clear();
        test_hold_reset();
        test_arbitration();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
